// File: rtl/mano_datapath_registers.sv
// Register slice of the basic Mano computer: AR (address), AC (accumulator)
// and DR (data). Each register takes its controls on the rising CLK edge.
// RST clears all three asynchronously.

// Clear/load/increment register, shared by AR and DR.
// Controls are prioritised clear > load > increment.
module mano_cnt_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Apply the highest-priority asserted control. Increment wraps modulo 2^W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (ld)  q <= d;
    else if (inc) q <= q + ONE;
  end

endmodule

module mano_datapath_registers #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AR_LD,
  input  logic              AR_INC,
  input  logic              AR_CLR,
  input  logic [ADDR_W-1:0] AR_IN,
  output logic [ADDR_W-1:0] AR_OUT,
  input  logic              AC_LD,
  input  logic              AC_CLR,
  input  logic              AC_COM,
  input  logic              AC_CIR,
  input  logic              AC_CIL,
  input  logic [DATA_W-1:0] AC_IN,
  output logic [DATA_W-1:0] AC_OUT,
  output logic              AC_ZERO,
  input  logic              DR_LD,
  input  logic              DR_INC,
  input  logic              DR_CLR,
  input  logic [DATA_W-1:0] DR_IN,
  output logic [DATA_W-1:0] DR_OUT,
  output logic              DR_ZERO
);

  logic [DATA_W-1:0] ac;

  mano_cnt_reg #(.W(ADDR_W)) u_ar (
    .clk (CLK),
    .rst (RST),
    .clr (AR_CLR),
    .ld  (AR_LD),
    .inc (AR_INC),
    .d   (AR_IN),
    .q   (AR_OUT)
  );

  mano_cnt_reg #(.W(DATA_W)) u_dr (
    .clk (CLK),
    .rst (RST),
    .clr (DR_CLR),
    .ld  (DR_LD),
    .inc (DR_INC),
    .d   (DR_IN),
    .q   (DR_OUT)
  );

  // Accumulator: only the highest-priority operation executes each edge.
  // Rotates are pure circular shifts; no E/carry bit takes part.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         ac <= '0;
    else if (AC_CLR) ac <= '0;
    else if (AC_LD)  ac <= AC_IN;
    else if (AC_COM) ac <= ~ac;
    else if (AC_CIR) ac <= {ac[0], ac[DATA_W-1:1]};
    else if (AC_CIL) ac <= {ac[DATA_W-2:0], ac[DATA_W-1]};
  end

  assign AC_OUT  = ac;
  // Zero flags decode register contents only.
  assign AC_ZERO = (ac == '0);
  assign DR_ZERO = (DR_OUT == '0);

endmodule

// File: tb/tb_mano_datapath_registers.sv
// Self-checking bench for mano_datapath_registers: directed test-plan
// sequences, then randomized controls compared against an integer model.
module tb_mano_datapath_registers;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int AMOD   = 1 << ADDR_W;
  localparam int DMOD   = 1 << DATA_W;

  logic              CLK = 1'b0;
  logic              RST;
  logic              AR_LD, AR_INC, AR_CLR;
  logic [ADDR_W-1:0] AR_IN;
  logic [ADDR_W-1:0] AR_OUT;
  logic              AC_LD, AC_CLR, AC_COM, AC_CIR, AC_CIL;
  logic [DATA_W-1:0] AC_IN;
  logic [DATA_W-1:0] AC_OUT;
  logic              AC_ZERO;
  logic              DR_LD, DR_INC, DR_CLR;
  logic [DATA_W-1:0] DR_IN;
  logic [DATA_W-1:0] DR_OUT;
  logic              DR_ZERO;

  int checks = 0;
  int errors = 0;

  // Reference state as plain integers.
  int m_ar, m_ac, m_dr;

  mano_datapath_registers #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .AR_LD   (AR_LD),
    .AR_INC  (AR_INC),
    .AR_CLR  (AR_CLR),
    .AR_IN   (AR_IN),
    .AR_OUT  (AR_OUT),
    .AC_LD   (AC_LD),
    .AC_CLR  (AC_CLR),
    .AC_COM  (AC_COM),
    .AC_CIR  (AC_CIR),
    .AC_CIL  (AC_CIL),
    .AC_IN   (AC_IN),
    .AC_OUT  (AC_OUT),
    .AC_ZERO (AC_ZERO),
    .DR_LD   (DR_LD),
    .DR_INC  (DR_INC),
    .DR_CLR  (DR_CLR),
    .DR_IN   (DR_IN),
    .DR_OUT  (DR_OUT),
    .DR_ZERO (DR_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    AR_LD = 0; AR_INC = 0; AR_CLR = 0; AR_IN = '0;
    AC_LD = 0; AC_CLR = 0; AC_COM = 0; AC_CIR = 0; AC_CIL = 0; AC_IN = '0;
    DR_LD = 0; DR_INC = 0; DR_CLR = 0; DR_IN = '0;
  endtask

  // Model one rising edge from the spec rules using arithmetic.
  task automatic model_edge();
    if (RST) begin
      m_ar = 0; m_ac = 0; m_dr = 0;
      return;
    end
    if (AR_CLR)      m_ar = 0;
    else if (AR_LD)  m_ar = int'(AR_IN);
    else if (AR_INC) m_ar = (m_ar + 1) % AMOD;

    if (DR_CLR)      m_dr = 0;
    else if (DR_LD)  m_dr = int'(DR_IN);
    else if (DR_INC) m_dr = (m_dr + 1) % DMOD;

    if (AC_CLR)      m_ac = 0;
    else if (AC_LD)  m_ac = int'(AC_IN);
    else if (AC_COM) m_ac = (DMOD - 1) - m_ac;
    else if (AC_CIR) m_ac = (m_ac / 2) + (m_ac % 2) * (DMOD / 2);
    else if (AC_CIL) m_ac = ((m_ac * 2) % DMOD) + (m_ac / (DMOD / 2));
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ar"}, int'(AR_OUT), m_ar);
    chk({tag, ".ac"}, int'(AC_OUT), m_ac);
    chk({tag, ".dr"}, int'(DR_OUT), m_dr);
    chk({tag, ".acz"}, int'(AC_ZERO), int'(m_ac == 0));
    chk({tag, ".drz"}, int'(DR_ZERO), int'(m_dr == 0));
  endtask

  // One clock: edge, model update, sample 1ns later.
  task automatic cyc(input string tag);
    @(posedge CLK);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  initial begin
    idle();
    RST = 1'b1;
    m_ar = 0; m_ac = 0; m_dr = 0;
    @(negedge CLK);
    chk_all("por");
    // Controls ignored while RST held across an edge.
    AR_LD = 1; AR_IN = 4'h7; AC_LD = 1; AC_IN = 8'h44; DR_INC = 1;
    cyc("rst_hold");
    idle();
    @(negedge CLK);
    RST = 1'b0;

    // Preload, then asynchronous reset between edges.
    AR_LD = 1; AR_IN = 4'h9; AC_LD = 1; AC_IN = 8'h5A; DR_LD = 1; DR_IN = 8'h33;
    cyc("preload");
    chk("preload_ac_lit", int'(AC_OUT), 8'h5A);
    idle();
    #2 RST = 1'b1;
    #1;
    m_ar = 0; m_ac = 0; m_dr = 0;
    chk_all("async_rst");
    chk("async_rst_acz", int'(AC_ZERO), 1);
    #1 RST = 1'b0;

    // AR load / increment / wrap / priority.
    AR_LD = 1; AR_IN = 4'hE; cyc("ar_ld");
    chk("ar_ld_lit", int'(AR_OUT), 4'hE);
    idle(); AR_INC = 1; cyc("ar_inc1");
    chk("ar_inc_f", int'(AR_OUT), 4'hF);
    cyc("ar_inc2");
    chk("ar_wrap", int'(AR_OUT), 0);
    AR_LD = 1; AR_INC = 1; AR_IN = 4'h3; cyc("ar_ld_inc");
    chk("ar_ld_over_inc", int'(AR_OUT), 4'h3);
    idle(); AR_CLR = 1; AR_LD = 1; AR_IN = 4'hA; cyc("ar_clr_ld");
    chk("ar_clr_over_ld", int'(AR_OUT), 0);

    // AC operations.
    idle(); AC_LD = 1; AC_IN = 8'b1001_0110; cyc("ac_ld");
    chk("ac_ld_lit", int'(AC_OUT), 8'h96);
    idle(); AC_COM = 1; cyc("ac_com");
    chk("ac_com_lit", int'(AC_OUT), 8'h69);
    idle(); AC_CIR = 1; cyc("ac_cir");
    chk("ac_cir_lit", int'(AC_OUT), 8'hB4);
    idle(); AC_CIL = 1; cyc("ac_cil");
    chk("ac_cil_lit", int'(AC_OUT), 8'h69);
    idle(); AC_CLR = 1; cyc("ac_clr");
    chk("ac_clr_zero", int'(AC_ZERO), 1);
    idle(); AC_LD = 1; AC_COM = 1; AC_IN = 8'h0F; cyc("ac_ld_com");
    chk("ac_ld_over_com", int'(AC_OUT), 8'h0F);
    idle(); AC_LD = 1; AC_IN = 8'h81; cyc("ac_81");
    idle(); AC_CIR = 1; AC_CIL = 1; cyc("ac_cir_cil");
    chk("ac_cir_over_cil", int'(AC_OUT), 8'hC0);

    // DR.
    idle(); DR_LD = 1; DR_IN = 8'hFE; cyc("dr_ld");
    chk("dr_ld_lit", int'(DR_OUT), 8'hFE);
    idle(); DR_INC = 1; cyc("dr_inc1");
    chk("dr_inc_ff", int'(DR_OUT), 8'hFF);
    cyc("dr_inc2");
    chk("dr_wrap_zero", int'(DR_ZERO), 1);
    idle(); DR_LD = 1; DR_IN = 8'h11; cyc("dr_ld2");
    idle(); DR_CLR = 1; DR_LD = 1; DR_IN = 8'h22; cyc("dr_clr_ld");
    chk("dr_clr_over_ld", int'(DR_OUT), 0);

    // Instruction flow: all three registers on one edge, then ADD / AND.
    idle(); AC_LD = 1; AC_IN = 8'h12; DR_LD = 1; DR_IN = 8'h05;
    AR_LD = 1; AR_IN = 4'h6; cyc("flow_ld");
    chk("flow_ar", int'(AR_OUT), 4'h6);
    idle(); AC_LD = 1; AC_IN = AC_OUT + DR_OUT; cyc("flow_add");
    chk("flow_add_lit", int'(AC_OUT), 8'h17);
    idle(); AC_LD = 1; AC_IN = AC_OUT & DR_OUT; cyc("flow_and");
    chk("flow_and_lit", int'(AC_OUT), 8'h05);

    // Randomized controls, including multi-control collisions.
    for (int i = 0; i < 400; i++) begin
      AR_LD  = ($urandom_range(3) == 0); AR_INC = ($urandom_range(1) == 0);
      AR_CLR = ($urandom_range(7) == 0); AR_IN  = ADDR_W'($urandom);
      AC_LD  = ($urandom_range(4) == 0); AC_CLR = ($urandom_range(9) == 0);
      AC_COM = ($urandom_range(3) == 0); AC_CIR = ($urandom_range(2) == 0);
      AC_CIL = ($urandom_range(2) == 0); AC_IN  = DATA_W'($urandom);
      DR_LD  = ($urandom_range(3) == 0); DR_INC = ($urandom_range(1) == 0);
      DR_CLR = ($urandom_range(7) == 0); DR_IN  = DATA_W'($urandom);
      if ($urandom_range(15) == 0) DR_IN = '0;
      cyc("rnd");
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
